// File: rtl/axi_traffic_gen.sv
// AXI4 traffic generator: writes an incrementing pattern burst, reads it back and
// counts mismatches. Channel field widths come from axi_tg_pkg; instance parameters must match.
package axi_tg_pkg;
   localparam int AXI_ADDR_W = 16;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_IDW_W  = 4;
   localparam int AXI_IDR_W  = 4;

   typedef struct packed {
      logic [AXI_IDW_W-1:0]    aw_id;
      logic [AXI_ADDR_W-1:0]   aw_addr;
      logic [7:0]              aw_len;
      logic [2:0]              aw_size;
      logic [1:0]              aw_burst;
      logic                    aw_lock;
      logic [3:0]              aw_cache;
      logic [2:0]              aw_prot;
      logic                    aw_valid;
      logic [AXI_DATA_W-1:0]   w_data;
      logic [AXI_DATA_W/8-1:0] w_strb;
      logic                    w_last;
      logic                    w_valid;
      logic                    b_ready;
      logic [AXI_IDR_W-1:0]    ar_id;
      logic [AXI_ADDR_W-1:0]   ar_addr;
      logic [7:0]              ar_len;
      logic [2:0]              ar_size;
      logic [1:0]              ar_burst;
      logic                    ar_lock;
      logic [3:0]              ar_cache;
      logic [2:0]              ar_prot;
      logic                    ar_valid;
      logic                    r_ready;
   } axi_mosi_t;

   typedef struct packed {
      logic                    aw_ready;
      logic                    w_ready;
      logic [AXI_IDW_W-1:0]    b_id;
      logic [1:0]              b_resp;
      logic                    b_valid;
      logic                    ar_ready;
      logic [AXI_IDR_W-1:0]    r_id;
      logic [AXI_DATA_W-1:0]   r_data;
      logic [1:0]              r_resp;
      logic                    r_last;
      logic                    r_valid;
   } axi_miso_t;
endpackage

module axi_traffic_gen
   import axi_tg_pkg::*;
#(
   parameter int ADDR_WIDTH = AXI_ADDR_W,
   parameter int DATA_WIDTH = AXI_DATA_W,
   parameter int ID_W_WIDTH = AXI_IDW_W,
   parameter int ID_R_WIDTH = AXI_IDR_W,
   parameter int TG_ID      = 0
)(
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [7:0]            len_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   output axi_mosi_t             out_mosi_o,
   input  axi_miso_t             out_miso_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [7:0]            err_cnt_o,
   output logic                  pass_o
);
   localparam logic [2:0]            AX_SIZE = 3'($clog2(DATA_WIDTH/8));
   localparam logic [1:0]            BURST_INCR = 2'b01;
   localparam logic [ID_W_WIDTH-1:0] AW_ID = ID_W_WIDTH'(TG_ID);
   localparam logic [ID_R_WIDTH-1:0] AR_ID = ID_R_WIDTH'(TG_ID);

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [DATA_WIDTH-1:0] seed_q;
   logic [7:0]            beat_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wlast_q;
   logic                  aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
   logic                  busy_q, done_q, pass_q;
   logic [7:0]            err_q;
   logic [7:0]            err_inc;
   logic                  b_bad, r_bad, r_end;

   assign err_inc = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;
   assign b_bad   = (out_miso_i.b_resp != 2'b00) || (out_miso_i.b_id != AW_ID);
   // At most one error per read beat, however many fields are wrong.
   assign r_bad   = (out_miso_i.r_data != seed_q + DATA_WIDTH'(beat_q)) ||
                    (out_miso_i.r_resp != 2'b00) || (out_miso_i.r_id != AR_ID) ||
                    (out_miso_i.r_last != (beat_q == len_q));
   assign r_end   = out_miso_i.r_last || (beat_q == len_q);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         seed_q     <= '0;
         beat_q     <= '0;
         wdata_q    <= '0;
         wlast_q    <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: if (start_i) begin
               addr_q     <= base_addr_i;
               len_q      <= len_i;
               seed_q     <= seed_i;
               beat_q     <= '0;
               err_q      <= '0;
               pass_q     <= 1'b0;
               busy_q     <= 1'b1;
               aw_valid_q <= 1'b1;
               state      <= S_AW;
            end
            S_AW: if (out_miso_i.aw_ready) begin
               aw_valid_q <= 1'b0;
               w_valid_q  <= 1'b1;
               wdata_q    <= seed_q;
               wlast_q    <= (len_q == 8'd0);
               beat_q     <= '0;
               state      <= S_W;
            end
            S_W: if (out_miso_i.w_ready) begin
               if (beat_q == len_q) begin
                  w_valid_q <= 1'b0;
                  wlast_q   <= 1'b0;
                  b_ready_q <= 1'b1;
                  state     <= S_B;
               end else begin
                  beat_q  <= beat_q + 8'd1;
                  wdata_q <= wdata_q + DATA_WIDTH'(1);
                  wlast_q <= (beat_q + 8'd1 == len_q);
               end
            end
            S_B: if (out_miso_i.b_valid) begin
               if (b_bad) err_q <= err_inc;
               b_ready_q  <= 1'b0;
               ar_valid_q <= 1'b1;
               state      <= S_AR;
            end
            S_AR: if (out_miso_i.ar_ready) begin
               ar_valid_q <= 1'b0;
               r_ready_q  <= 1'b1;
               beat_q     <= '0;
               state      <= S_R;
            end
            S_R: if (out_miso_i.r_valid) begin
               if (r_bad) err_q <= err_inc;
               if (r_end) begin
                  r_ready_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  pass_q    <= ((r_bad ? err_inc : err_q) == 8'd0);
                  beat_q    <= '0;
                  state     <= S_DONE;
               end else begin
                  beat_q <= beat_q + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      out_mosi_o          = '0;
      out_mosi_o.aw_id    = AW_ID;
      out_mosi_o.aw_addr  = addr_q;
      out_mosi_o.aw_len   = len_q;
      out_mosi_o.aw_size  = AX_SIZE;
      out_mosi_o.aw_burst = BURST_INCR;
      out_mosi_o.aw_valid = aw_valid_q;
      out_mosi_o.w_data   = wdata_q;
      out_mosi_o.w_strb   = '1;
      out_mosi_o.w_last   = wlast_q;
      out_mosi_o.w_valid  = w_valid_q;
      out_mosi_o.b_ready  = b_ready_q;
      out_mosi_o.ar_id    = AR_ID;
      out_mosi_o.ar_addr  = addr_q;
      out_mosi_o.ar_len   = len_q;
      out_mosi_o.ar_size  = AX_SIZE;
      out_mosi_o.ar_burst = BURST_INCR;
      out_mosi_o.ar_valid = ar_valid_q;
      out_mosi_o.r_ready  = r_ready_q;
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_cnt_o = err_q;
   assign pass_o    = pass_q;
endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen with a behavioural AXI RAM slave and protocol monitors.
module tb_axi_traffic_gen;
   import axi_tg_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] base_addr_i = '0;
   logic [7:0]  len_i = '0;
   logic [31:0] seed_i = '0;
   axi_mosi_t   m;
   axi_miso_t   s;
   logic        busy_o, done_o, pass_o;
   logic [7:0]  err_cnt_o;

   int n_assert = 0;
   int n_fail = 0;

   always #5 clk_in = ~clk_in;

   axi_traffic_gen #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_W_WIDTH(4), .ID_R_WIDTH(4), .TG_ID(0)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
      .len_i(len_i), .seed_i(seed_i), .out_mosi_o(m), .out_miso_i(s),
      .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .pass_o(pass_o));

   // slave knobs, written only by the stimulus block
   logic       stall_en = 1'b0;
   logic       corrupt_all = 1'b0;
   int         corrupt_beat = -1;
   logic [1:0] bresp_inj = 2'b00;

   logic [31:0] mem [0:16383];
   logic [15:0] waddr, raddr;
   logic [7:0]  wlen, rlen;
   int          wbeat, rbeat;
   logic        w_act, b_pend, r_act;

   function automatic logic rdy();
      return !stall_en || ($urandom_range(0, 2) == 0);
   endfunction

   function automatic logic [13:0] widx(input logic [15:0] a, input int b);
      logic [15:0] t;
      t = a + 16'(b * 4);
      return t[15:2];
   endfunction

   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s <= '0; w_act <= 1'b0; b_pend <= 1'b0; r_act <= 1'b0;
         wbeat <= 0; rbeat <= 0; waddr <= '0; raddr <= '0; wlen <= '0; rlen <= '0;
      end else begin
         s.aw_ready <= rdy();
         s.w_ready  <= rdy();
         s.ar_ready <= rdy();
         if (m.aw_valid && s.aw_ready) begin
            waddr <= m.aw_addr; wlen <= m.aw_len; wbeat <= 0; w_act <= 1'b1;
         end
         if (m.w_valid && s.w_ready && w_act) begin
            mem[widx(waddr, wbeat)] <= m.w_data;
            wbeat <= wbeat + 1;
            if (wbeat == int'(wlen)) begin w_act <= 1'b0; b_pend <= 1'b1; end
         end
         if (s.b_valid && m.b_ready) begin
            s.b_valid <= 1'b0; b_pend <= 1'b0;
         end else if (b_pend && !s.b_valid && rdy()) begin
            s.b_valid <= 1'b1; s.b_resp <= bresp_inj; s.b_id <= 4'd0;
         end
         if (m.ar_valid && s.ar_ready) begin
            raddr <= m.ar_addr; rlen <= m.ar_len; rbeat <= 0; r_act <= 1'b1;
         end
         if (s.r_valid && m.r_ready) begin
            s.r_valid <= 1'b0; rbeat <= rbeat + 1;
            if (s.r_last) r_act <= 1'b0;
         end else if (r_act && !s.r_valid && rdy()) begin
            s.r_valid <= 1'b1;
            s.r_data  <= mem[widx(raddr, rbeat)] ^
                         ((corrupt_all || rbeat == corrupt_beat) ? 32'h1 : 32'h0);
            s.r_last  <= (rbeat == int'(rlen));
            s.r_resp  <= 2'b00;
            s.r_id    <= 4'd0;
         end
      end
   end

   // monitors: channel overlap, payload stability under stall, WLAST placement
   int          ovl_err = 0, stab_err = 0, wlast_err = 0, w_hs = 0;
   logic        aw_st, w_st, ar_st;
   logic [15:0] aw_a, ar_a;
   logic [7:0]  aw_l, ar_l;
   logic [31:0] w_d;
   logic        w_l;

   always @(posedge clk_in) begin
      if (rst_n) begin
         if ($countones({m.aw_valid, m.w_valid, m.b_ready, m.ar_valid, m.r_ready}) > 1)
            ovl_err <= ovl_err + 1;
         if ((aw_st && (!m.aw_valid || m.aw_addr != aw_a || m.aw_len != aw_l)) ||
             (w_st && (!m.w_valid || m.w_data != w_d || m.w_last != w_l)) ||
             (ar_st && (!m.ar_valid || m.ar_addr != ar_a || m.ar_len != ar_l)))
            stab_err <= stab_err + 1;
         if (m.w_valid && s.w_ready) begin
            w_hs <= w_hs + 1;
            if (m.w_last != (wbeat == int'(wlen))) wlast_err <= wlast_err + 1;
         end
      end
      aw_st <= rst_n && m.aw_valid && !s.aw_ready;
      w_st  <= rst_n && m.w_valid && !s.w_ready;
      ar_st <= rst_n && m.ar_valid && !s.ar_ready;
      aw_a <= m.aw_addr; aw_l <= m.aw_len; ar_a <= m.ar_addr; ar_l <= m.ar_len;
      w_d <= m.w_data; w_l <= m.w_last;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] b, input logic [7:0] l, input logic [31:0] sd);
      @(negedge clk_in);
      base_addr_i = b; len_i = l; seed_i = sd; start_i = 1'b1;
      @(negedge clk_in);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_o) break;
         @(negedge clk_in);
      end
      check({tag, "_done"}, done_o, 1'b1);
   endtask

   int base_hs;

   initial begin
      // reset state
      #12;
      check("rst_valids", {m.aw_valid, m.w_valid, m.b_ready, m.ar_valid, m.r_ready}, 5'b0);
      check("rst_flags", {busy_o, done_o, pass_o, err_cnt_o}, 11'b0);
      @(negedge clk_in); rst_n = 1'b1;

      // basic burst, len=3
      start(16'h0010, 8'd3, 32'hA5A5_0000);
      check("t1_awvalid", m.aw_valid, 1'b1);
      check("t1_awaddr", m.aw_addr, 16'h0010);
      check("t1_awlen", m.aw_len, 8'd3);
      check("t1_awsize_burst", {m.aw_size, m.aw_burst}, {3'd2, 2'b01});
      check("t1_busy", busy_o, 1'b1);
      wait_done("t1", 200);
      check("t1_err", err_cnt_o, 8'd0);
      check("t1_pass", pass_o, 1'b1);
      check("t1_mem0", mem[4], 32'hA5A5_0000);
      check("t1_mem3", mem[7], 32'hA5A5_0003);
      @(negedge clk_in);
      check("t1_done_pulse", done_o, 1'b0);
      check("t1_hold", {busy_o, pass_o}, 2'b01);

      // single beat at top of address space
      base_hs = w_hs;
      start(16'hFFFC, 8'd0, 32'hFFFF_FFFF);
      for (int i = 0; i < 20 && !m.w_valid; i++) @(negedge clk_in);
      check("t2_wlast_beat0", {m.w_valid, m.w_last}, 2'b11);
      wait_done("t2", 200);
      check("t2_pass", {pass_o, err_cnt_o}, {1'b1, 8'd0});
      check("t2_mem", mem[16'h3FFF], 32'hFFFF_FFFF);
      check("t2_beats", w_hs - base_hs, 1);

      // one corrupted read beat
      corrupt_beat = 2;
      start(16'h0800, 8'd7, 32'h0000_1000);
      wait_done("t3", 300);
      check("t3_err", err_cnt_o, 8'd1);
      check("t3_pass", pass_o, 1'b0);
      corrupt_beat = -1;

      // random ready/valid stalls, same pattern as t1
      stall_en = 1'b1;
      start(16'h0A00, 8'd3, 32'hA5A5_0000);
      wait_done("t4", 2000);
      check("t4_pass", {pass_o, err_cnt_o}, {1'b1, 8'd0});
      check("t4_mem1", mem[16'h0281], 32'hA5A5_0001);
      check("t4_mem3", mem[16'h0283], 32'hA5A5_0003);
      stall_en = 1'b0;

      // start while busy is ignored
      base_hs = w_hs;
      start(16'h0100, 8'd1, 32'h1234_5678);
      base_addr_i = 16'h0300; len_i = 8'd5; seed_i = 32'h0; start_i = 1'b1;
      @(negedge clk_in); start_i = 1'b0;
      wait_done("t5", 300);
      check("t5_pass", pass_o, 1'b1);
      check("t5_beats", w_hs - base_hs, 2);
      check("t5_mem1", mem[16'h0041], 32'h1234_5679);

      // slave error response
      bresp_inj = 2'b10;
      start(16'h0400, 8'd1, 32'h0000_0077);
      wait_done("t6", 300);
      check("t6_err", err_cnt_o, 8'd1);
      check("t6_pass", pass_o, 1'b0);

      // saturation: 256 bad beats plus bad BRESP
      corrupt_all = 1'b1;
      start(16'h0000, 8'd255, 32'h0);
      check("t7_err_cleared", err_cnt_o, 8'd0);
      wait_done("t7", 3000);
      check("t7_err_sat", err_cnt_o, 8'd255);
      check("t7_pass", pass_o, 1'b0);
      corrupt_all = 1'b0; bresp_inj = 2'b00;

      // reset during W beat 1, then a fresh test
      base_hs = w_hs;
      start(16'h0200, 8'd3, 32'h0000_5000);
      for (int i = 0; i < 50 && w_hs == base_hs; i++) @(negedge clk_in);
      check("t8_wbeat1", {m.w_valid, m.w_data}, {1'b1, 32'h0000_5001});
      rst_n = 1'b0;
      #1;
      check("t8_rst_valids", {m.aw_valid, m.w_valid, m.b_ready, m.ar_valid, m.r_ready}, 5'b0);
      check("t8_rst_flags", {busy_o, done_o, pass_o, err_cnt_o}, 11'b0);
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      start(16'h0200, 8'd3, 32'h0000_6000);
      wait_done("t8", 300);
      check("t8_pass", {pass_o, err_cnt_o}, {1'b1, 8'd0});
      check("t8_mem3", mem[16'h0083], 32'h0000_6003);

      // protocol monitors over the whole run
      check("mon_overlap", ovl_err, 0);
      check("mon_stable", stab_err, 0);
      check("mon_wlast", wlast_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_traffic_gen.md
AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16, AXI byte-address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits (multiple of 8).
REQ-003 The module SHALL have parameter ID_W_WIDTH, default 4, AW/B ID width.
REQ-004 The module SHALL have parameter ID_R_WIDTH, default 4, AR/R ID width.
REQ-005 The module SHALL have parameter TG_ID, default 0, ID driven on AWID/ARID and expected on BID/RID.
REQ-006 The module SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The module SHALL have port start_i, input, 1, a one-cycle pulse that launches a test.
REQ-009 The module SHALL have port base_addr_i, input, ADDR_WIDTH, the burst start address, sampled on start.
REQ-010 The module SHALL have port len_i, input, 8, AXI LEN (beats-1), sampled on start.
REQ-011 The module SHALL have port seed_i, input, DATA_WIDTH, the pattern seed, sampled on start.
REQ-012 The module SHALL have port out_mosi_o, output, axi_mosi_t, the manager-driven AXI channels toward the RAM slave.
REQ-013 The module SHALL have port out_miso_i, input, axi_miso_t, the slave-driven AXI channels.
REQ-014 The module SHALL have port busy_o, output, 1, high in every state except IDLE and DONE.
REQ-015 The module SHALL have port done_o, output, 1, a one-cycle pulse on entry to DONE.
REQ-016 The module SHALL have port err_cnt_o, output, 8, the saturating error count of the last test.
REQ-017 The module SHALL have port pass_o, output, 1, high in DONE when err_cnt_o==0.

Function
REQ-018 The FSM SHALL use states IDLE, AW, W, B, AR, R, DONE.
REQ-019 IDLE/DONE + start_i SHALL go to AW next cycle, latch inputs, clear err_cnt_o; start_i in other states SHALL be ignored.
REQ-020 DONE SHALL hold, keeping err_cnt_o/pass_o, until start_i.
REQ-021 AW SHALL drive AWVALID=1, AWADDR=base, AWLEN=len, AWSIZE=log2(DATA_WIDTH/8), AWBURST=INCR, AWID=TG_ID, with payload stable until AWREADY; the handshake cycle goes to W.
REQ-022 W SHALL drive WVALID=1, WDATA=seed+beat (mod 2^DATA_WIDTH, beat 0..len), WSTRB all ones, WLAST=1 only on beat==len; the beat advances only on WVALID&WREADY; the last-beat handshake goes to B.
REQ-023 B SHALL drive BREADY=1; on BVALID, BRESP!=OKAY or BID!=TG_ID SHALL add 1 error; then go to AR.
REQ-024 AR SHALL mirror AW on AR fields (ARID=TG_ID); ARREADY handshake goes to R.
REQ-025 R SHALL drive RREADY=1; each RVALID beat with RDATA!=seed+beat, RRESP!=OKAY, RID!=TG_ID, or RLAST!=(beat==len) SHALL add exactly 1 error (max one per beat).
REQ-026 The R beat carrying RLAST, or beat==len, SHALL end R and go to DONE.
REQ-027 Only one channel VALID/READY SHALL be asserted at a time; AW and W do not overlap.
REQ-028 err_cnt_o SHALL saturate at 255.
REQ-029 len_i=0 SHALL produce single-beat bursts with WLAST on the only beat.
REQ-030 Addresses SHALL wrap modulo 2^ADDR_WIDTH; 4 KB crossing is the user's responsibility.
REQ-031 All outputs SHALL be registered; no combinational path from out_miso_i to out_mosi_o.
REQ-032 A manager field not named above SHALL be driven to 0.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, all VALID/READY=0, busy_o=0, done_o=0, err_cnt_o=0, pass_o=0, beat counter=0.
REQ-034 Reset mid-burst SHALL abandon the transaction without completion; the first start after reset release begins a fresh test.

Verification
REQ-035 Against axi_ram: base=0x0010, len=3, seed=0xA5A50000 -> writes 0xA5A50000..03, reads match, done_o pulse, err_cnt_o=0, pass_o=1.
REQ-036 len=0, seed=0xFFFFFFFF, base=0xFFFC -> one beat, WLAST on beat 0, pass_o=1.
REQ-037 Slave model corrupts read beat 2 of len=7 -> err_cnt_o=1, pass_o=0.
REQ-038 Random READY stalls of 0-5 cycles on all channels -> payload stable while VALID&!READY, result identical to the no-stall run.
REQ-039 rst_n pulsed low during W beat 1 -> all VALIDs 0 at once; a new start then completes with pass_o=1.
REQ-040 start_i pulsed while busy -> ignored, no parameter change; a slave returning BRESP=SLVERR -> err_cnt_o=1.
